// File: rtl/seven_seg_scan_ctrl_if.sv
// rtl/seven_seg_scan_ctrl_if.sv - update strobe and decoder/digit-drive bundle for the scan controller
interface seven_seg_scan_ctrl_if #(
  parameter int DIGITS = 2
);
  logic                  upd;
  logic [4*DIGITS-1:0]   upd_codes;
  logic [DIGITS-1:0]     upd_coll;
  logic [3:0]            dec_code;
  logic                  dec_coll;
  logic [DIGITS-1:0]     dig_sel_n;
  logic                  frame_start;

  modport master (
    output upd, upd_codes, upd_coll,
    input  dec_code, dec_coll, dig_sel_n, frame_start
  );

  modport slave (
    input  upd, upd_codes, upd_coll,
    output dec_code, dec_coll, dig_sel_n, frame_start
  );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - time-multiplexed seven-segment digit scanner with blanking and tear-free updates
module seven_seg_scan_ctrl #(
  parameter int DIGITS       = 2,
  parameter int DWELL_CYCLES = 4096,
  parameter int BLANK_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seven_seg_scan_ctrl_if.slave bus
);

  localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [3:0]    CODE_BLANK = 4'hE;

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  logic [0:0]          state, state_nx;
  logic [CW-1:0]       cnt, cnt_nx;
  logic [IW-1:0]       idx, idx_nx;
  logic                wrap;

  logic [4*DIGITS-1:0] shadow_codes, active_codes;
  logic [DIGITS-1:0]   shadow_coll, active_coll;
  logic                pending;

  logic [DIGITS-1:0]   sel_nx;
  logic [3:0]          code_nx;
  logic                coll_nx;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 1'b1;
    idx_nx   = idx;
    wrap     = 1'b0;
    if (state == ST_BLANK) begin
      if (cnt == BLANK_LAST) begin
        state_nx = ST_SHOW;
        cnt_nx   = '0;
      end
    end else begin
      if (cnt == DWELL_LAST) begin
        state_nx = ST_BLANK;
        cnt_nx   = '0;
        wrap     = (idx == IDX_LAST);
        idx_nx   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
    end
  end

  // Outputs are decoded from the next state so they are registered yet aligned with the state.
  // Active contents only change on a wrap (entering BLANK), so the current active set is valid here.
  always_comb begin
    sel_nx  = '1;
    code_nx = CODE_BLANK;
    coll_nx = 1'b0;
    if (state_nx == ST_SHOW) begin
      for (int d = 0; d < DIGITS; d++) begin
        if (idx_nx == IW'(d)) begin
          sel_nx[d] = 1'b0;
          code_nx   = active_codes[4*d +: 4];
          coll_nx   = active_coll[d];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= ST_BLANK;
      cnt             <= '0;
      idx             <= '0;
      shadow_codes    <= {DIGITS{CODE_BLANK}};
      active_codes    <= {DIGITS{CODE_BLANK}};
      shadow_coll     <= '0;
      active_coll     <= '0;
      pending         <= 1'b0;
      bus.dig_sel_n   <= '1;
      bus.dec_code    <= CODE_BLANK;
      bus.dec_coll    <= 1'b0;
      bus.frame_start <= 1'b0;
    end else begin
      state           <= state_nx;
      cnt             <= cnt_nx;
      idx             <= idx_nx;
      bus.dig_sel_n   <= sel_nx;
      bus.dec_code    <= code_nx;
      bus.dec_coll    <= coll_nx;
      bus.frame_start <= wrap;

      // A transfer on the wrap edge sees the old shadow; a coincident upd stays pending.
      if (wrap && pending) begin
        active_codes <= shadow_codes;
        active_coll  <= shadow_coll;
      end
      if (bus.upd) begin
        shadow_codes <= bus.upd_codes;
        shadow_coll  <= bus.upd_coll;
        pending      <= 1'b1;
      end else if (wrap) begin
        pending      <= 1'b0;
      end
    end
  end

endmodule

// File: doc/seven_seg_scan_ctrl.md
# seven_seg_scan_ctrl

Time-multiplexed scan controller that shares the single `Seven_seg_decoder` instance across `DIGITS` common-anode digit positions on the antenna-switch front panel. It holds a shadow/active register pair per digit and inserts a blanking gap between digits to suppress ghosting. It drives the decoder's `I`/`I_collision` inputs and the active-low digit enables. Display updates are tear-free: new values are applied only at frame boundaries.

## Interface
- `DIGITS`, 2: number of multiplexed digit positions (≥1).
- `DWELL_CYCLES`, 4096: clock cycles each digit is lit (≥1).
- `BLANK_CYCLES`, 64: clock cycles all digits are dark before each digit (≥1).

Ports:
- `clk`  in  1  system clock; only clock.
- `rst_n`  in  1  synchronous, active-low reset. One clock; reset is synchronous and active-low.
- `upd`  in  1  single-cycle strobe; captures `upd_codes`/`upd_coll` into the shadow registers.
- `upd_codes`  in  4*DIGITS  digit d code in bits [4d+3:4d]; passed to the decoder unmodified (0–9, A = dp, F = dash, E = blank).
- `upd_coll`  in  DIGITS  bit d = collision flag for digit d.
- `dec_code`  out  4  to decoder `I`.
- `dec_coll`  out  1  to decoder `I_collision`.
- `dig_sel_n`  out  DIGITS  active-low one-cold digit enable.
- `frame_start`  out  1  one-cycle pulse at each frame boundary.

## Operation
- FSM states: BLANK and SHOW. Registers: dwell/blank counter `cnt`, digit index `idx` (0..DIGITS-1), shadow and active code/collision arrays, and a `pending` flag.
- BLANK: `dig_sel_n` = all ones, `dec_code` = 4'hE, `dec_coll` = 0. When `cnt` reaches BLANK_CYCLES-1, go to SHOW and clear `cnt`.
- SHOW: `dig_sel_n[idx]` = 0 and all other bits = 1; `dec_code` = active code[idx]; `dec_coll` = active coll[idx]. When `cnt` reaches DWELL_CYCLES-1, go to BLANK, clear `cnt`, and set `idx` = idx+1 (wrapping DIGITS-1 → 0).
- Wrap event: leaving SHOW with idx = DIGITS-1.
  - `frame_start` = 1 in the first BLANK cycle of the new frame.
  - If `pending` is set, copy shadow → active and clear `pending` in that same transition.
- `upd`: shadow ← inputs and `pending` ← 1, accepted in any state. Multiple `upd` within one frame: the last one wins.
- `upd` in the wrap-transition cycle: the transfer uses the old shadow contents. The new data lands in the shadow and `pending` stays 1, so it is applied at the next wrap.
- Collision precedence is handled by the decoder: `dec_coll` = 1 displays 'C' regardless of `dec_code`.
- No other arithmetic. `cnt` width = clog2(max(DWELL_CYCLES, BLANK_CYCLES)); `idx` width = clog2(DIGITS), minimum 1.

## Timing
- All outputs are registered and change only on the `clk` rising edge.
- Reset (`rst_n` = 0 sampled at an edge) puts the block in BLANK with idx = 0 and cnt = 0.
  - Outputs: `dig_sel_n` all ones, `dec_code` 4'hE, `dec_coll` 0, `frame_start` 0.
  - Active and shadow codes = 4'hE, collision flags = 0, `pending` = 0.
- Reset asserted mid-SHOW or mid-BLANK takes effect on the next edge. Any pending update is discarded.
- From the first cycle after reset release:
  - BLANK occupies cycles 0..B-1.
  - Digit 0 SHOW occupies B..B+D-1, where B = BLANK_CYCLES and D = DWELL_CYCLES.
  - Digit d SHOW starts at cycle d·(B+D)+B.
  - Frame period = DIGITS·(B+D).
- `frame_start` is not asserted after reset. It first pulses at cycle DIGITS·(B+D).
- Update latency, from `upd` to the first lit cycle showing the new value: at most DIGITS·(B+D)+B cycles and at least B+1 cycles.
- Digit enables are never asserted in overlapping cycles; between any two lit digits there are exactly B dark cycles.

## Test plan
Settings: DIGITS=2, DWELL_CYCLES=8, BLANK_CYCLES=2.

1. **Reset:** hold `rst_n`=0 for 3 cycles, then release → cycles 0–1: `dig_sel_n`=2'b11, `dec_code`=E. Cycles 2–9: `dig_sel_n`=2'b10, `dec_code`=E, `dec_coll`=0. Cycles 10–11 dark. Cycles 12–19: 2'b01. Cycle 20: `frame_start`=1.
2. **Update apply:** `upd` at cycle 5 with `upd_codes`=8'h53, `upd_coll`=0 → frame 0 still shows E on both digits. Cycle 20: `frame_start`=1. Cycles 22–29: `dec_code`=3 with 2'b10. Cycles 32–39: `dec_code`=5 with 2'b01.
3. **Collision:** `upd_coll`=2'b10, `upd_codes`=8'h21 → after the next wrap, digit 0 shows `dec_code`=1 with `dec_coll`=0, and digit 1 shows `dec_coll`=1.
4. **Last-wins / boundary update:**
   - Two `upd` strobes (8'h11, then 8'h77) within one frame → only 7/7 is displayed.
   - `upd` asserted on the cycle-19 wrap transition with 8'h44 → frame 1 shows the prior values; 4/4 appears in frame 2; `frame_start` pulses in both frames.
5. **Reset mid-operation:** apply `rst_n`=0 at cycle 25 while pending=1 and digit 0 is lit → next cycle `dig_sel_n`=2'b11, `dec_code`=E. After release, the sequence restarts as in scenario 1 with blank content.
6. **Anti-ghosting:** check over 5 frames → `dig_sel_n` is never 2'b00. Every transition between 2'b10 and 2'b01 has exactly 2 cycles of 2'b11 with `dec_code`=E in between.
